// File: rtl/add_seq32.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice reused over WIDTH/4 cycles.
// Optional subtract support is enabled by defining ADD_SEQ32_SUB_EN.
module add_seq32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_flag,
    output logic             v_flag,
    output logic             z_flag,
    output logic             n_flag
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    // Effective operand and initial carry chosen at acceptance time.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef ADD_SEQ32_SUB_EN
    always_comb begin
        b_eff   = op ? ~b : b;
        cin_eff = op ? 1'b1 : ci;
    end
`else
    logic unused_op;
    assign unused_op = op;

    always_comb begin
        b_eff   = b;
        cin_eff = ci;
    end
`endif

    // 4-bit carry-lookahead slice on the low nibble of the operand shift registers.
    logic [3:0] nib_g;
    logic [3:0] nib_p;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       co;
    logic [3:0] nib_s;

    always_comb begin
        nib_g = a_q[3:0] & b_q[3:0];
        nib_p = a_q[3:0] ^ b_q[3:0];
        c1    = nib_g[0] | (nib_p[0] & carry_q);
        c2    = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
        c3    = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
              | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
        co    = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
              | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
              | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
        nib_s = nib_p ^ {c3, c2, c1, carry_q};
    end

    // Result nibbles enter at the top so the LSB nibble ends up at bit 0 after the last step.
    logic [WIDTH-1:0] sum_next;
    assign sum_next = {nib_s, sum_q[WIDTH-1:4]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            c_flag  <= 1'b0;
            v_flag  <= 1'b0;
            z_flag  <= 1'b0;
            n_flag  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= {4'b0000, a_q[WIDTH-1:4]};
                    b_q     <= {4'b0000, b_q[WIDTH-1:4]};
                    sum_q   <= sum_next;
                    carry_q <= co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_NIB) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        s       <= sum_next;
                        c_flag  <= co;
                        v_flag  <= c3 ^ co;
                        z_flag  <= (sum_next == '0);
                        n_flag  <= sum_next[WIDTH-1];
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
